i2s_encoder: RTL and testbench
==============================

Name: i2s_encoder

Overview:
- Serial transmitter for the 3-wire audio link that the core's sync-word receiver already decodes.
- Sends continuous 40-bit frames, MSB first: 8-bit sync 0xAA, then left[15:0], then right[15:0].
- Generates SCK from `clk` and drives SD, which changes only on SCK falling edges.
- Takes samples through a one-entry valid/ready buffer. Sits between the audio mixer and the output pins or the companion FPGA link.

Parameters:
- CLKDIV_HALF, 4: `clk` cycles per SCK half-period. Minimum 2. The receiver needs at least 3 of its own clocks per SCK half-period.
- SYNC_WORD, 8'hAA: frame sync byte.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- left_in  in  16  left sample, two's complement.
- right_in  in  16  right sample.
- in_valid  in  1  sample offered this cycle.
- in_ready  out  1  buffer can accept a sample; transfer when in_valid && in_ready.
- sck  out  1  serial bit clock.
- sd  out  1  serial data.
- frame_start  out  1  one-cycle pulse when the first sync bit is driven.
- underrun  out  1  one-cycle pulse when a frame repeats the previous sample.

Behaviour:
- Reset values:
  - sck=1, sd=0, in_ready=1, frame_start=0, underrun=0.
  - Divider count=0, bit index=0, buffer empty.
  - Hold and last-sample registers=0.
  - Preamble flag=1.
- Divider:
  - Count 0..CLKDIV_HALF-1. At terminal count, toggle sck and wrap to 0.
  - The first edge after reset is a falling edge, exactly CLKDIV_HALF cycles after rst deasserts.
- Bit timing:
  - All sd updates happen in the same `clk` cycle that sck goes 1->0.
  - sd is held for a full SCK period, so it is stable across the receiver's rising-edge sample.
- Preamble:
  - After reset, 40 SCK periods with sd=0 flush the receiver's shift register.
  - No frame_start and no underrun during the preamble.
  - The buffer may fill during the preamble.
- Frame load (falling edge with bit index 0, preamble done):
  - Shift register <= {SYNC_WORD, L, R}. sd <= bit 39. frame_start=1 for that cycle.
  - Source of L, R, in priority order:
    1. Buffer full: use the buffered sample; buffer becomes empty.
    2. Buffer empty and in_valid this cycle: bypass the input directly into the frame; buffer stays empty; counts as a transfer.
    3. Otherwise: repeat the last transmitted sample and pulse underrun.
  - The last-sample register updates with the sample actually sent.
- Other falling edges:
  - Shift left, sd <= new MSB.
  - Bit index increments 0..39 and wraps to 0, so frames run back-to-back with no gap.
- Buffer:
  - in_ready = ~full.
  - Accepting a sample sets full.
  - Accept and frame load never collide on the same entry: a full buffer has in_ready=0, and the empty case uses bypass.
- Frame period = 80*CLKDIV_HALF `clk` cycles; frame_start pulses exactly that far apart.
- Reset mid-frame:
  - Immediate return to reset values; the partial frame is abandoned.
  - Buffered sample is discarded. The preamble repeats before the next frame.
- in_valid held with in_ready=0: no effect; inputs may change freely.
- Latency: a sample accepted into an empty buffer goes out at the next frame load. Its first sync bit is on sd at that load cycle; its last right bit is on sd 39 SCK periods later.

Decomposition:
- Shared audio-link package holds:
  - SYNC_WORD = 8'hAA.
  - FRAME_BITS = 40, SYNC_BITS = 8, SAMPLE_BITS = 16.
  - The frame-layout field offsets, shared with the receiver.
- One sub-module is natural: i2s_sck_gen. It holds the divider and sck register and outputs one-cycle fall_tick and rise_tick strobes. The encoder proper uses only fall_tick.

Test Plan:
- Reset, in_valid with L=16'h1234, R=16'hABCD, CLKDIV_HALF=4:
  - First falling edge at cycle 4.
  - 40 zero bits, then frame_start.
  - Serial stream AA 12 34 AB CD, MSB first.
  - Loopback receiver outputs left=1234, right=ABCD.
- Steady state, CLKDIV_HALF=4:
  - SCK period is 8 clk.
  - frame_start spacing is 320 clk.
  - sd never changes except in the cycle sck falls.
- No further samples after 16'h1234/16'hABCD:
  - Next frame repeats 1234/ABCD and underrun pulses once per frame.
  - in_valid with L=16'h8000, R=16'h7FFF then appears in the following frame; no underrun.
- Push two samples (1111/2222, then 3333/4444) mid-frame:
  - First is accepted; in_ready=0 afterwards.
  - 1111/2222 goes out at the next load, and in_ready returns to 1 that cycle.
  - 3333/4444 is accepted then and sent the frame after.
- Empty buffer, in_valid asserted only in the load cycle with 5555/6666:
  - Bypass: that frame carries 5555/6666, no underrun, buffer stays empty.
- rst asserted at bit 20 of a frame:
  - sck=1 and sd=0 next cycle.
  - Preamble repeats, then frames resume.
  - Receiver re-locks with no false sample after the preamble.

Source files
------------

// File: rtl/i2s_encoder_pkg.sv
// Audio-link definitions shared by the serial encoder and the sync-word receiver.
// Frame is MSB first: sync byte, then left sample, then right sample.
package i2s_encoder_pkg;

    localparam int FRAME_BITS  = 40;
    localparam int SYNC_BITS   = 8;
    localparam int SAMPLE_BITS = 16;
    localparam logic [SYNC_BITS-1:0] SYNC_WORD = 8'hAA;

    localparam int SYNC_MSB  = FRAME_BITS - 1;
    localparam int LEFT_MSB  = SYNC_MSB - SYNC_BITS;
    localparam int RIGHT_MSB = LEFT_MSB - SAMPLE_BITS;

    localparam int BIT_IDX_W = $clog2(FRAME_BITS);

    typedef struct packed {
        logic [SAMPLE_BITS-1:0] left;
        logic [SAMPLE_BITS-1:0] right;
    } sample_t;

    typedef enum logic {
        ST_PREAMBLE,
        ST_STREAM
    } state_t;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [SYNC_BITS-1:0] sync,
        input sample_t              smp
    );
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[SYNC_MSB  -: SYNC_BITS]   = sync;
        f[LEFT_MSB  -: SAMPLE_BITS] = smp.left;
        f[RIGHT_MSB -: SAMPLE_BITS] = smp.right;
        return f;
    endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// Bit-clock divider: sck toggles every CLKDIV_HALF clk cycles, first edge is a fall.
// fall_tick/rise_tick are high in the cycle whose closing clk edge moves sck.
module i2s_sck_gen #(
    parameter int CLKDIV_HALF = 4
) (
    input  logic clk,
    input  logic rst,
    output logic sck,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int CW = $clog2(CLKDIV_HALF);
    localparam logic [CW-1:0] TERM = CW'(CLKDIV_HALF - 1);

    logic [CW-1:0] cnt;
    logic          term;

    assign term      = (cnt == TERM);
    assign fall_tick = term & sck;
    assign rise_tick = term & ~sck;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            sck <= 1'b1;
        end else if (term) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_encoder.sv
// Serial audio transmitter: 40-bit frames {sync, left, right} back-to-back after a zero preamble.
// One-entry sample buffer with valid/ready; an empty buffer at frame load bypasses or repeats.
module i2s_encoder
    import i2s_encoder_pkg::*;
#(
    parameter int                   CLKDIV_HALF = 4,
    parameter logic [SYNC_BITS-1:0] SYNC_WORD   = i2s_encoder_pkg::SYNC_WORD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SAMPLE_BITS-1:0] left_in,
    input  logic [SAMPLE_BITS-1:0] right_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   sck,
    output logic                   sd,
    output logic                   frame_start,
    output logic                   underrun
);

    logic                  fall_tick;
    logic                  rise_tick;
    state_t                state;
    state_t                state_nxt;
    logic [BIT_IDX_W-1:0]  bit_idx;
    logic                  last_bit;
    logic                  load;
    logic [FRAME_BITS-2:0] shreg;
    logic                  full;
    logic                  accept;
    sample_t               hold;
    sample_t               last;
    sample_t               load_smp;
    logic [FRAME_BITS-1:0] frame;

    i2s_sck_gen #(
        .CLKDIV_HALF (CLKDIV_HALF)
    ) u_sck_gen (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .fall_tick (fall_tick),
        .rise_tick (rise_tick)
    );

    // The shift logic relies on the two strobes being mutually exclusive.
    assert property (@(posedge clk) disable iff (rst) !(fall_tick && rise_tick));

    assign in_ready = ~full;
    assign accept   = in_valid & ~full;
    assign last_bit = (bit_idx == BIT_IDX_W'(FRAME_BITS - 1));

    // Buffered sample wins; otherwise the live input is bypassed; otherwise repeat.
    assign load_smp = full     ? hold :
                      in_valid ? '{left: left_in, right: right_in} :
                                 last;
    assign frame    = build_frame(SYNC_WORD, load_smp);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        if (fall_tick) begin
            case (state)
                ST_PREAMBLE: if (last_bit) state_nxt = ST_STREAM;
                ST_STREAM:   load = (bit_idx == '0);
                default:     state_nxt = ST_PREAMBLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_PREAMBLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx     <= '0;
            shreg       <= '0;
            sd          <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            full        <= 1'b0;
            hold        <= '0;
            last        <= '0;
        end else begin
            frame_start <= load;
            underrun    <= load & ~full & ~in_valid;

            // During the preamble bit_idx counts the 40 flush periods; sd stays 0.
            if (fall_tick) begin
                bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
                if (load) begin
                    sd    <= frame[FRAME_BITS-1];
                    shreg <= frame[FRAME_BITS-2:0];
                    last  <= load_smp;
                end else if (state == ST_STREAM) begin
                    sd    <= shreg[FRAME_BITS-2];
                    shreg <= {shreg[FRAME_BITS-3:0], 1'b0};
                end
            end

            if (load) begin
                full <= 1'b0;
            end else if (accept) begin
                full <= 1'b1;
                hold <= '{left: left_in, right: right_in};
            end
        end
    end

endmodule

// File: tb/tb_i2s_encoder.sv
// Directed scoreboard bench: stimulus queues expected frames, a loopback monitor
// captures sd on sck rising edges from each frame_start and compares.
module tb_i2s_encoder;

    localparam int HALF   = 4;
    localparam int PERIOD = 80 * HALF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] left_in = '0;
    logic [15:0] right_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sck;
    logic        sd;
    logic        frame_start;
    logic        underrun;

    i2s_encoder #(
        .CLKDIV_HALF (HALF),
        .SYNC_WORD   (8'hAA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .left_in     (left_in),
        .right_in    (right_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sck         (sck),
        .sd          (sd),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        ur;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   since_rst = 0;
    int   frames_done = 0;

    always @(posedge clk) since_rst <= rst ? 0 : since_rst + 1;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d after reset)", name, act, exp, since_rst);
        end
    endtask

    function automatic void push(input logic [15:0] l, input logic [15:0] r, input logic ur);
        exp_t e;
        e.l = l;
        e.r = r;
        e.ur = ur;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 400);
        check(name, 40'(frame_start), 40'd1);
    endtask

    // Loopback monitor / receiver
    initial begin
        logic        prev_sck = 1'b1;
        logic        prev_sd = 1'b0;
        int          last_fall = -1;
        int          last_fs = -1;
        bit          capturing = 1'b0;
        int          nbits = 0;
        logic [39:0] cap = '0;
        exp_t        cur;
        cur.l = '0; cur.r = '0; cur.ur = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_fall = -1;
                last_fs   = -1;
                capturing = 1'b0;
                nbits     = 0;
            end else begin
                if (sd !== prev_sd)
                    check("sd_change_on_fall", 40'(prev_sck === 1'b1 && sck === 1'b0), 40'd1);
                if (prev_sck === 1'b1 && sck === 1'b0) begin
                    if (last_fall < 0) check("first_fall_time", 40'(since_rst), 40'(HALF));
                    else               check("sck_period", 40'(since_rst - last_fall), 40'(2 * HALF));
                    last_fall = since_rst;
                end
                if (underrun === 1'b1)
                    check("underrun_with_frame_start", 40'(frame_start), 40'd1);
                if (frame_start === 1'b1) begin
                    if (last_fs < 0) check("first_frame_time", 40'(since_rst), 40'(PERIOD + HALF));
                    else             check("frame_spacing", 40'(since_rst - last_fs), 40'(PERIOD));
                    last_fs = since_rst;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 40'd1, 40'd0);
                        capturing = 1'b0;
                    end else begin
                        cur = exp_q.pop_front();
                        check("underrun", 40'(underrun), 40'(cur.ur));
                        capturing = 1'b1;
                        nbits = 0;
                    end
                end
                if (prev_sck === 1'b0 && sck === 1'b1) begin
                    if (capturing) begin
                        cap = {cap[38:0], sd};
                        nbits++;
                        if (nbits == 40) begin
                            check("sync", 40'(cap[39:32]), 40'h0AA);
                            check("left", 40'(cap[31:16]), 40'(cur.l));
                            check("right", 40'(cap[15:0]), 40'(cur.r));
                            capturing = 1'b0;
                            frames_done++;
                        end
                    end else if (last_fs < 0) begin
                        check("preamble_sd", 40'(sd), 40'd0);
                    end
                end
            end
            prev_sck = sck;
            prev_sd  = sd;
        end
    end

    // Stimulus
    initial begin
        int s5;
        int s8;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_sck", 40'(sck), 40'd1);
        check("rst_sd", 40'(sd), 40'd0);
        check("rst_in_ready", 40'(in_ready), 40'd1);
        check("rst_frame_start", 40'(frame_start), 40'd0);
        check("rst_underrun", 40'(underrun), 40'd0);
        rst = 1'b0;

        // Sample buffered during the preamble
        in_valid = 1'b1; left_in = 16'h1234; right_in = 16'hABCD;
        push(16'h1234, 16'hABCD, 1'b0);
        tick();
        in_valid = 1'b0;
        check("full_after_accept", 40'(in_ready), 40'd0);

        wait_fs("fs1");
        check("buffer_freed_at_load", 40'(in_ready), 40'd1);
        push(16'h1234, 16'hABCD, 1'b1);

        wait_fs("fs2");
        repeat (40) tick();
        in_valid = 1'b1; left_in = 16'h8000; right_in = 16'h7FFF;
        push(16'h8000, 16'h7FFF, 1'b0);
        tick();
        in_valid = 1'b0;

        // Two samples mid-frame: second waits for the buffer to drain at load
        wait_fs("fs3");
        repeat (50) tick();
        in_valid = 1'b1; left_in = 16'h1111; right_in = 16'h2222;
        push(16'h1111, 16'h2222, 1'b0);
        tick();
        check("in_ready_low_when_full", 40'(in_ready), 40'd0);
        left_in = 16'h3333; right_in = 16'h4444;
        push(16'h3333, 16'h4444, 1'b0);
        begin
            int n = 0;
            do begin
                tick();
                n++;
            end while (!in_ready && n < 400);
        end
        check("ready_returns_at_load", 40'(frame_start), 40'd1);
        tick();
        in_valid = 1'b0;
        check("second_accepted", 40'(in_ready), 40'd0);

        // Bypass: valid only in the load cycle with an empty buffer
        wait_fs("fs5");
        s5 = since_rst;
        while (since_rst < s5 + PERIOD - 1) tick();
        push(16'h5555, 16'h6666, 1'b0);
        push(16'h5555, 16'h6666, 1'b1);
        in_valid = 1'b1; left_in = 16'h5555; right_in = 16'h6666;
        tick();
        in_valid = 1'b0;
        check("bypass_load_cycle", 40'(frame_start), 40'd1);
        check("bypass_buffer_empty", 40'(in_ready), 40'd1);

        wait_fs("fs7");
        in_valid = 1'b1; left_in = 16'hFFFF; right_in = 16'h0000;
        push(16'hFFFF, 16'h0000, 1'b0);
        tick();
        in_valid = 1'b0;

        // Reset at bit 20 of frame 8 (left bit 3 = 1 on sd)
        wait_fs("fs8");
        s8 = since_rst;
        while (since_rst < s8 + 20 * 2 * HALF + 2) tick();
        check("sd_before_rst", 40'(sd), 40'd1);
        check("sck_before_rst", 40'(sck), 40'd0);
        rst = 1'b1;
        tick();
        check("midrst_sck", 40'(sck), 40'd1);
        check("midrst_sd", 40'(sd), 40'd0);
        check("midrst_in_ready", 40'(in_ready), 40'd1);
        tick();
        rst = 1'b0;
        in_valid = 1'b1; left_in = 16'h0F0F; right_in = 16'hF0F0;
        push(16'h0F0F, 16'hF0F0, 1'b0);
        tick();
        in_valid = 1'b0;
        wait_fs("fs_after_rst");
        check("fs_after_rst_time", 40'(since_rst), 40'(PERIOD + HALF));
        push(16'h0F0F, 16'hF0F0, 1'b1);
        wait_fs("fs_final");
        repeat (PERIOD - 2) tick();
        check("queue_drained", 40'(exp_q.size()), 40'd0);
        check("frames_completed", 40'(frames_done), 40'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 20000 cycles");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
